asmi_flash_loader: RTL

- Avalon-MM initiator that drives the ams_mem slave port of the ASMI flash controller.
- Accepts a command (flash word address, word count) and writes the controller's 16-bit window-offset CSR whenever the 64K-word window changes.
- Issues window-bounded burst reads and streams the returned words out through an internal FIFO with valid/ready backpressure.
- Sits between the flash-update/boot logic and the ASMI controller.

---
 rtl/asmi_loader_pkg.sv | 19 +
 rtl/asmi_loader_fifo.sv | 43 ++++
 rtl/asmi_flash_loader.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/asmi_loader_pkg.sv
// Shared types, constants and the CRC-32 word update for the ASMI flash loader.
package asmi_loader_pkg;

   typedef enum logic [2:0] {IDLE, SET_OFS, RD_REQ, RD_DATA, DRAIN} state_t;

   localparam int          WINDOW_BITS  = 16;
   localparam int          CSR_SEL_BIT  = 16;
   localparam logic [31:0] CRC32_POLY_R = 32'hEDB88320;

   // Reflected CRC-32 over one 32-bit word, byte 0 first, each byte LSB first.
   function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [31:0] data);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 32; i++)
         c = (c >> 1) ^ (CRC32_POLY_R & {32{c[0] ^ data[i]}});
      return c;
   endfunction

endpackage

// File: rtl/asmi_loader_fifo.sv
// Synchronous show-ahead FIFO; rd_data presents the head entry, free reports empty slots.
module asmi_loader_fifo #(
   parameter int DEPTH = 128,
   parameter int WIDTH = 32
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   free
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr, count;
   logic             do_push, do_pop;

   assign count   = wr_ptr - rd_ptr;
   assign empty   = (count == '0);
   assign free    = (AW+1)'(DEPTH) - count;
   assign do_pop  = pop && !empty;
   assign do_push = push && (count != (AW+1)'(DEPTH));
   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/asmi_flash_loader.sv
// Avalon-MM initiator reading ASMI flash through the 64K-word window, streaming words out.
// Optional CRC-32 of the streamed words: define ASMI_LOADER_CRC_EN to add crc_out.
module asmi_flash_loader
   import asmi_loader_pkg::*;
#(
   parameter int          MAX_BURST  = 64,
   parameter int          FIFO_DEPTH = 128,
   parameter logic [15:0] OFFSET_REG = 16'h0064
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [25:0] cmd_addr,
   input  logic [23:0] cmd_len,
   output logic        busy,
   output logic        done,
   output logic        ams_mem_read,
   output logic        ams_mem_write,
   output logic [16:0] ams_mem_address,
   output logic [6:0]  ams_mem_burstcount,
   output logic [31:0] ams_mem_writedata,
   input  logic [31:0] ams_mem_readdata,
   input  logic        ams_mem_waitrequest,
   input  logic        ams_mem_readdatavalid,
`ifdef ASMI_LOADER_CRC_EN
   output logic [31:0] crc_out,
`endif
   output logic [31:0] st_data,
   output logic        st_valid,
   input  logic        st_ready
);

   localparam int FAW = $clog2(FIFO_DEPTH);

   state_t       state, state_nxt;
   logic [25:0]  addr, nxt_addr;
   logic [23:0]  remaining;
   logic [9:0]   ofs_cache;
   logic         ofs_valid, run;
   logic [6:0]   burst, burst_q, beats;
   logic [16:0]  win_left, rem_cap;
   logic [FAW:0] fifo_free;
   logic [31:0]  fifo_data;
   logic         fifo_empty, accept, read_go, csr_done, rd_accept, beat_in, last_beat, pop;

   // Burst never crosses the window edge nor exceeds what is left or MAX_BURST.
   always_comb begin
      win_left = 17'h1_0000 - {1'b0, addr[15:0]};
      rem_cap  = (remaining > 24'(MAX_BURST)) ? 17'(MAX_BURST) : remaining[16:0];
      burst    = (rem_cap < win_left) ? rem_cap[6:0] : win_left[6:0];
   end

   assign accept    = cmd_valid && cmd_ready;
   assign read_go   = (state == RD_REQ) && (fifo_free >= (FAW+1)'(burst));
   assign csr_done  = (state == SET_OFS) && !ams_mem_waitrequest;
   assign rd_accept = read_go && !ams_mem_waitrequest;
   assign beat_in   = (state == RD_DATA) && ams_mem_readdatavalid;
   assign last_beat = beat_in && (beats == 7'd1);
   assign nxt_addr  = addr + 26'(burst_q);
   assign st_valid  = !fifo_empty;
   assign st_data   = st_valid ? fifo_data : '0;
   assign pop       = st_valid && st_ready;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:
            if (accept) begin
               if (cmd_len == '0)                                      state_nxt = DRAIN;
               else if (!ofs_valid || ofs_cache != cmd_addr[25:16])   state_nxt = SET_OFS;
               else                                                    state_nxt = RD_REQ;
            end
         SET_OFS: if (!ams_mem_waitrequest) state_nxt = RD_REQ;
         RD_REQ:  if (rd_accept)            state_nxt = RD_DATA;
         RD_DATA:
            if (last_beat) begin
               if (remaining == 24'(burst_q))          state_nxt = DRAIN;
               else if (nxt_addr[25:16] != ofs_cache)  state_nxt = SET_OFS;
               else                                    state_nxt = RD_REQ;
            end
         DRAIN:   if (fifo_empty) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready          = run && (state == IDLE);
      busy               = (state != IDLE);
      done               = (state == DRAIN) && fifo_empty;
      ams_mem_read       = 1'b0;
      ams_mem_write      = 1'b0;
      ams_mem_address    = '0;
      ams_mem_burstcount = '0;
      ams_mem_writedata  = '0;
      case (state)
         SET_OFS: begin
            ams_mem_write                         = 1'b1;
            ams_mem_address[CSR_SEL_BIT]          = 1'b1;
            ams_mem_address[WINDOW_BITS-1:0]      = OFFSET_REG;
            ams_mem_writedata                     = {22'd0, addr[25:16]};
            ams_mem_burstcount                    = 7'd1;
         end
         RD_REQ: begin
            ams_mem_read                          = read_go;
            ams_mem_address[WINDOW_BITS-1:0]      = addr[15:0];
            ams_mem_burstcount                    = burst;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         run       <= 1'b0;
         ofs_valid <= 1'b0;
         beats     <= '0;
      end else begin
         run <= 1'b1;
         if (csr_done)     ofs_valid <= 1'b1;
         if (rd_accept)    beats <= burst;
         else if (beat_in) beats <= beats - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (accept) begin
         addr      <= cmd_addr;
         remaining <= cmd_len;
      end else if (last_beat) begin
         addr      <= nxt_addr;
         remaining <= remaining - 24'(burst_q);
      end
      if (csr_done)  ofs_cache <= addr[25:16];
      if (rd_accept) burst_q   <= burst;
   end

   asmi_loader_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (beat_in),
      .wr_data (ams_mem_readdata),
      .pop     (pop),
      .rd_data (fifo_data),
      .empty   (fifo_empty),
      .free    (fifo_free)
   );

`ifdef ASMI_LOADER_CRC_EN
   // Running register holds the un-inverted CRC so its reset value maps to crc_out = 0.
   logic [31:0] crc_state;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)    crc_state <= 32'hFFFF_FFFF;
      else if (accept) crc_state <= 32'hFFFF_FFFF;
      else if (pop)    crc_state <= crc32_next(crc_state, fifo_data);
   end
   assign crc_out = ~crc_state;
`endif

endmodule
